// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with sign correction at the end.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nRST,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     count;
    logic              neg_main;
    logic              neg_rem;

    logic              a_signed, b_signed, sign_a, sign_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   special_val;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed, rem_fixed;
    logic [XLEN-1:0]   fix_val;

    // Operand decode on the raw inputs; only consulted on the accepting edge.
    always_comb begin
        a_signed    = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_signed    = funct3[2] ? !funct3[0] : !funct3[1];
        sign_a      = a_signed & rs1_data[XLEN-1];
        sign_b      = b_signed & rs2_data[XLEN-1];
        mag_a       = sign_a ? ('0 - rs1_data) : rs1_data;
        mag_b       = sign_b ? ('0 - rs2_data) : rs2_data;
        div_zero    = funct3[2] && (rs2_data == '0);
        div_ovf     = funct3[2] && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
        special_val = '0;
        if (div_zero)
            special_val = funct3[1] ? rs1_data : '1;
        else if (div_ovf)
            special_val = funct3[1] ? '0 : MIN_NEG;
    end

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = !div_diff[XLEN];
        div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc[XLEN-2:0], div_ge};
    end

    always_comb begin
        prod_fixed = neg_main ? ('0 - acc) : acc;
        quo_fixed  = neg_main ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_fixed  = neg_rem  ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 fix_val = prod_fixed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fixed[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fixed;
            default:                fix_val = rem_fixed;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            op       <= '0;
            opnd     <= '0;
            acc      <= '0;
            count    <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        op       <= funct3;
                        count    <= '0;
                        neg_main <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        if (funct3[2]) begin
                            opnd <= mag_b;
                            acc  <= {{XLEN{1'b0}}, mag_a};
                        end else begin
                            opnd <= mag_a;
                            acc  <= {{XLEN{1'b0}}, mag_b};
                        end
                        if (div_zero || div_ovf) begin
                            result <= special_val;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    acc   <= op[2] ? div_next : mul_next;
                    count <= count + CW'(1);
                    if (count == CW'(XLEN-1))
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_val;
                    state  <= DONE;
                end
                DONE: begin
                    // busy stays high through the done cycle; IDLE drops it next edge
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

    logic        clk;
    logic        nRST;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t dir_vecs [14] = '{
        '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
        '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
        '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34},
        '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34},
        '{3'b101, 32'd100,       32'd7,         32'd14,        34},
        '{3'b111, 32'd100,       32'd7,         32'd2,         34},
        '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
        '{3'b110, 32'd5,         32'd0,         32'd5,         1},
        '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1},
        '{3'b101, 32'd9,         32'd0,         32'hFFFF_FFFF, 1},
        '{3'b111, 32'd9,         32'd0,         32'd9,         1}
    };

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Launch one op, scramble inputs after acceptance, observe a 40-cycle window.
    task automatic exec_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res,
                           output int pulses, output int busy_err);
        lat = -1; pulses = 0; busy_err = 0; res = '0;
        @(negedge clk);
        funct3 = f3; rs1_data = a; rs2_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        if (busy !== 1'b1) busy_err++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    res = result;
                end
            end
            if (busy !== ((lat < 0 || lat == n) ? 1'b1 : 1'b0)) busy_err++;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        #2 nRST = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h want=0", result); end
        @(negedge clk); @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic test_directed();
        int lat, pulses, busy_err;
        logic [31:0] res;
        for (int i = 0; i < 14; i++) begin
            exec_op(dir_vecs[i].f3, dir_vecs[i].a, dir_vecs[i].b, lat, res, pulses, busy_err);
            n_cmp++; if (res !== dir_vecs[i].exp) begin n_bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, dir_vecs[i].exp); end
            n_cmp++; if (lat != dir_vecs[i].lat) begin n_bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, dir_vecs[i].lat); end
            n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL dir%0d_done_pulses got=%0d want=1", i, pulses); end
            n_cmp++; if (busy_err != 0) begin n_bad++; $display("FAIL dir%0d_busy bad_samples=%0d want=0", i, busy_err); end
            n_cmp++; if (result !== dir_vecs[i].exp) begin n_bad++; $display("FAIL dir%0d_result_held got=%h want=%h", i, result, dir_vecs[i].exp); end
        end
    endtask

    task automatic test_random();
        int lat, pulses, busy_err, exp_lat;
        logic [31:0] res, a, b, exp;
        logic [2:0]  f3;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp = model(f3, a, b);
            exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
            exec_op(f3, a, b, lat, res, pulses, busy_err);
            n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got=%h want=%h", i, f3, a, b, res, exp); end
            n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, exp_lat); end
            n_cmp++; if (pulses != 1 || busy_err != 0) begin n_bad++; $display("FAIL rnd%0d_handshake pulses=%0d busy_err=%0d want 1/0", i, pulses, busy_err); end
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int pulses = 0;
        logic [31:0] res = '0;
        @(negedge clk);
        funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5;
        for (int n = 1; n <= 40; n++) begin
            if (n == 10) begin
                start = 1'b1; funct3 = 3'b011; rs1_data = $urandom; rs2_data = $urandom;
            end
            @(posedge clk); #1;
            if (n == 10) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin lat = n; res = result; end
            end
        end
        n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL ignore_result got=%h want=%h", res, 32'd14); end
        n_cmp++; if (lat != 34) begin n_bad++; $display("FAIL ignore_latency got=%0d want=34", lat); end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ignore_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_reset_midop();
        int lat, pulses, busy_err, stray;
        logic [31:0] res;
        @(negedge clk);
        funct3 = 3'b000; rs1_data = $urandom | 32'h1; rs2_data = $urandom | 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3 nRST = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b want=0", done); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL midrst_result got=%h want=0", result); end
        @(negedge clk); @(negedge clk);
        nRST = 1'b1;
        stray = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL midrst_no_done stray_samples=%0d want=0", stray); end
        exec_op(3'b000, 32'd3, 32'd4, lat, res, pulses, busy_err);
        n_cmp++; if (res !== 32'd12) begin n_bad++; $display("FAIL postrst_result got=%h want=%h", res, 32'd12); end
        n_cmp++; if (lat != 34) begin n_bad++; $display("FAIL postrst_latency got=%0d want=34", lat); end
        n_cmp++; if (pulses != 1 || busy_err != 0) begin n_bad++; $display("FAIL postrst_handshake pulses=%0d busy_err=%0d want 1/0", pulses, busy_err); end
    endtask

    task automatic test_back_to_back();
        int          times[$];
        logic [31:0] vals[$];
        logic [31:0] a1, b1, a2, b2, e1, e2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'h100;
        e1 = model(3'b011, a1, b1);
        e2 = model(3'b110, a2, b2);
        @(negedge clk);
        funct3 = 3'b011; rs1_data = a1; rs2_data = b1; start = 1'b1;
        @(posedge clk); #1;
        funct3 = 3'b110; rs1_data = a2; rs2_data = b2;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (n == 35) start = 1'b0;
            if (done === 1'b1) begin
                times.push_back(n);
                vals.push_back(result);
            end
        end
        n_cmp++; if (times.size() != 2) begin n_bad++; $display("FAIL b2b_pulses got=%0d want=2", times.size()); end
        if (times.size() >= 2) begin
            n_cmp++; if (times[0] != 34) begin n_bad++; $display("FAIL b2b_first_latency got=%0d want=34", times[0]); end
            n_cmp++; if (times[1] != 69) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=69", times[1]); end
            n_cmp++; if (vals[0] !== e1) begin n_bad++; $display("FAIL b2b_first_result got=%h want=%h", vals[0], e1); end
            n_cmp++; if (vals[1] !== e2) begin n_bad++; $display("FAIL b2b_second_result got=%h want=%h", vals[1], e2); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit, directly downstream of register_file. It consumes read_data1/read_data2 as rs1/rs2 operands and produces a 32-bit result for the writeback mux into register_file write_data. The unit stalls the core through busy; the control unit holds the PC and gates reg_write until done pulses.

Parameters:
XLEN, 32, operand/result width; iteration counter width is $clog2(XLEN).

Ports:
clk  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
start  input  1  request to launch an operation; sampled only in IDLE
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  operand A (multiplicand/dividend), from read_data1
rs2_data  input  XLEN  operand B (multiplier/divisor), from read_data2
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid, writeback enable
result  output  XLEN  operation result; held stable until the next accepted start

Behaviour:
- Reset: clk is clk; reset is nRST, asynchronous, active-low. On reset: state=IDLE, busy=0, done=0, result=0, counter=0, all internal operand/accumulator registers=0. Reset mid-operation aborts the op with no done pulse.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: if start=1 at an edge, latch funct3 and operands (converted to magnitudes for signed variants, original signs recorded), clear counter. Next state is CALC, except for the special cases below, which go directly to DONE.
- Special cases, resolved in IDLE in one cycle:
  - divide by zero (rs2=0): DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> rs1.
  - signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- CALC: one iteration per cycle, XLEN cycles (counter 0..XLEN-1).
  - Multiply: shift-add over a 2*XLEN product register.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - After iteration XLEN-1, go to FIX.
- FIX: apply sign correction, then go to DONE.
  - MUL: low XLEN of the signed product.
  - MULH: high XLEN, both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: unsigned high.
  - DIV: quotient negated if the operand signs differ; truncation toward zero.
  - REM: remainder takes the sign of the dividend.
  - Register the corrected value into result.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Latency:
  - Normal op with start sampled at edge k: done high in the cycle after edge k+XLEN+2 (k+34 for XLEN=32).
  - Special case: done high in the cycle after edge k+1.
- start while busy=1 (CALC/FIX/DONE) is ignored, with no effect on the in-flight op. start held high continuously launches a new op at the first IDLE edge after DONE.
- Operand inputs and funct3 may change freely after the accepting edge; only latched copies are used.
- Widths: multiply product is 2*XLEN; MUL and MULHU results must match the low and high halves of the exact product. No X propagation on result at any time.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done pulses exactly 34 cycles after the start edge; busy high for cycles 1..34.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. All four give done one cycle after start.
- start pulsed again at cycle 10 of a DIVU, with changed operands -> ignored; original result delivered at cycle 34, with exactly one done pulse.
- nRST asserted at cycle 15 of a MUL -> busy=0, done=0, result=0 immediately. After release, a fresh MUL 3*4 -> 12 with normal latency.
